stage_to_buffer_bb: RTL
=======================

# stage_to_buffer_BB

Unloads a completed FFT stage into a downstream buffer_BB, one word per cycle. It reads stage memory sequentially and reads the matching metadata word from the mstore. Each data word is packed with its metadata and written into the buffer under full-flag backpressure. It is the output-side counterpart of the buffer-to-stage loader and sits between a stage/mstore pair and the next buffer_BB.

## Interface
Parameters:
- N, 8: points per transform (power of two, ≥ 2).
- LOG_N, 3: log2(N).
- WIDTH, 32: sample width.
- MWIDTH, 1: metadata width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- start  in  1  one-cycle pulse that begins unloading one transform.
- out_addr  out  LOG_N  read address to the stage memory and the mstore.
- out_rd  out  1  read strobe to the stage and the mstore.
- in_data  in  WIDTH  stage read data; valid exactly 1 cycle after out_rd.
- in_m  in  MWIDTH  mstore read data; valid exactly 1 cycle after out_rd.
- write_full  in  1  buffer_BB cannot accept a write next cycle.
- write_nd  out  1  write strobe to buffer_BB.
- write_data  out  WIDTH+MWIDTH  {sample, m}, sample in the MSBs.
- finished  out  1  one-cycle pulse coinciding with the N-th write_nd.
- error  out  1  sticky; start seen while busy.

## Operation
- States:
  - IDLE: accepts start.
  - ACTIVE: issues reads.
  - DRAIN: all N reads issued; waiting for the last write.
- IDLE + start → ACTIVE:
  - addr=0, rd_count=0, wr_count=0.
- start while not IDLE:
  - error←1, held until reset.
  - start is otherwise ignored; the transfer in progress continues unaffected.
- In-flight tracking:
  - A 1-bit pipeline flag marks the cycle in which in_data/in_m are valid.
  - The block has no input valid from the stage.
- Skid FIFO:
  - 2 entries, holding {in_data,in_m}.
  - credit = FIFO occupancy + reads in flight, range 0..2.
- Read issue, ACTIVE only:
  - out_rd=1 iff credit − (pop this cycle) < 2.
  - addr increments after each read.
  - After the N-th read (addr N−1): → DRAIN.
- Write path:
  - pop = (FIFO non-empty or returning data) and ~write_full.
  - Head priority is FIFO head first, then returning data (bypass when FIFO empty).
  - Non-popped returning data is pushed.
  - On pop: write_data←head, write_nd←1 in the next cycle; wr_count increments.
- Completion:
  - On the pop that makes wr_count = N, finished←1 (visible with that write_nd) and state → IDLE.
  - start is accepted in the cycle finished is high.
- Contract with buffer_BB:
  - write_full low in cycle t guarantees acceptance of a write_nd in cycle t+1.
- Counters: rd_count and wr_count are LOG_N+1 bits wide; addr wraps naturally at N.
- Reset, asynchronous, including mid-transfer:
  - State IDLE.
  - FIFO and in-flight flag cleared.
  - out_addr=0, out_rd=0, write_nd=0, write_data=0, finished=0, error=0.
  - Data from the aborted transfer is never written.

## Timing
- start high in cycle c, write_full never high:
  - out_rd high in cycles c+1..c+N, addresses 0..N−1.
  - in_data valid in cycles c+2..c+N+1.
  - write_nd high in cycles c+3..c+N+2.
  - finished high in cycle c+N+2.
- Throughput: 1 word/cycle.
- Latency: 2 cycles from out_rd to write_nd.
- write_full high in cycle t: no write_nd in cycle t+1.
- Reads stall once credit = 2; at most 2 words are ever outstanding.
- All outputs are registered.

## Structure
- Shared fft package:
  - Packed-word helpers: concatenation order and the WIDTH+MWIDTH width.
  - State encoding constants (IDLE/ACTIVE/DRAIN).
- Sub-module: skid_fifo2 (2-deep, parameterised width, push/pop/occupancy).
  - It is reusable by other stage-side unloaders.

## Test plan
- N=8, write_full low, stage[i]=0x100+i, m[i]=i&1, start at c=0 → write_data {0x100+i, i&1} for i=0..7 in cycles 3..10; finished in cycle 10 only.
- write_full high cycles 4–7 → no write_nd in cycles 5–8; out_rd pauses after credit hits 2; all 8 words arrive in order; exactly one finished.
- write_full high from start until cycle 12 → exactly 2 out_rd (addresses 0,1) before stall; after release, 8 ordered writes.
- start again in cycle 5 of a transfer → error=1 and stays 1; the running transfer completes with correct data and a single finished.
- rst_n low at cycle 6 mid-transfer → all outputs 0 immediately; after release, a new start produces a clean 8-word transfer with no stale words.
- start in the same cycle as finished → accepted, error stays 0; second transfer's first out_rd appears in the next cycle.

Source files
------------

// File: rtl/stage_to_buffer_bb_pkg.sv
// Shared definitions for the stage-to-buffer_BB unloader: controller state
// encoding, skid FIFO sizing and the packed {sample, m} word width.
package stage_to_buffer_bb_pkg;

  // Controller states: waiting for start, issuing reads, waiting for last write
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } stage_state_e;

  // Occupancy counter width of the two-entry skid FIFO (counts 0..2)
  localparam int SKID_CNT_W = 2;

  // Total words that may be buffered or in flight at once
  localparam logic [2:0] SKID_CREDITS = 3'd2;

  // Packed word layout is {sample, m} with the sample in the MSBs, so the
  // packed width is simply the sum of the two field widths.
  function automatic int packed_width(input int sample_w, input int meta_w);
    return sample_w + meta_w;
  endfunction

endpackage

// File: rtl/stage_to_buffer_bb_skid_fifo2.sv
// Two-entry skid FIFO with push/pop and occupancy. Pop reads the head that is
// visible combinationally on dout in the same cycle. Reusable by other
// stage-side unloaders.
module skid_fifo2
  import stage_to_buffer_bb_pkg::*;
#(
  parameter int W = 33
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [W-1:0]          din,
  output logic [W-1:0]          dout,
  output logic [SKID_CNT_W-1:0] count,
  output logic                  empty
);

  logic [W-1:0]          entry0_q, entry0_d;
  logic [W-1:0]          entry1_q, entry1_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [SKID_CNT_W-1:0] count_q, count_d;

  // Next-state for storage, pointers and occupancy
  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      if (wr_ptr_q) begin
        entry1_d = din;
      end else begin
        entry0_d = din;
      end
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers, cleared on reset so no stale word survives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry0_q <= '0;
      entry1_q <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = rd_ptr_q ? entry1_q : entry0_q;
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/stage_to_buffer_bb.sv
// Unloads one completed FFT stage into a downstream buffer_BB. Reads stage
// memory and mstore sequentially, packs {sample, m} and writes one word per
// cycle under full-flag backpressure. At most two words are ever held between
// the read port and the write port (skid FIFO occupancy plus reads in flight).
module stage_to_buffer_bb
  import stage_to_buffer_bb_pkg::*;
#(
  parameter int N      = 8,
  parameter int LOG_N  = 3,
  parameter int WIDTH  = 32,
  parameter int MWIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic [LOG_N-1:0]        out_addr,
  output logic                    out_rd,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [MWIDTH-1:0]       in_m,
  input  logic                    write_full,
  output logic                    write_nd,
  output logic [WIDTH+MWIDTH-1:0] write_data,
  output logic                    finished,
  output logic                    error
);

  localparam int             PW      = packed_width(WIDTH, MWIDTH);
  localparam logic [LOG_N:0] CNT_N   = N[LOG_N:0];
  localparam logic [LOG_N:0] CNT_ONE = {{LOG_N{1'b0}}, 1'b1};

  stage_state_e      state_q, state_d;
  logic [LOG_N:0]    rd_count_q, rd_count_d;
  logic [LOG_N:0]    wr_count_q, wr_count_d;
  logic [LOG_N-1:0]  out_addr_q, out_addr_d;
  logic              out_rd_q, out_rd_d;
  logic              valid_q, valid_d;
  logic              write_nd_q, write_nd_d;
  logic [PW-1:0]     write_data_q, write_data_d;
  logic              finished_q, finished_d;
  logic              error_q, error_d;

  logic [PW-1:0]         ret_word;
  logic [PW-1:0]         head;
  logic                  pop;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [PW-1:0]         fifo_dout;
  logic [SKID_CNT_W-1:0] fifo_count;
  logic                  fifo_empty;

  logic                  starting;
  logic [LOG_N:0]        rd_base;
  logic [LOG_N:0]        rd_next;
  logic [LOG_N:0]        wr_next;
  logic [2:0]            credit;
  logic [2:0]            credit_limit;

  skid_fifo2 #(
    .W(PW)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (ret_word),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  // Write path: FIFO head has priority, returning data bypasses an empty FIFO
  always_comb begin
    ret_word  = {in_data, in_m};
    pop       = (!fifo_empty || valid_q) && !write_full;
    head      = fifo_empty ? ret_word : fifo_dout;
    fifo_pop  = pop && !fifo_empty;
    fifo_push = valid_q && !(pop && fifo_empty);
  end

  // Controller: start handling, credit-limited read issue, completion
  always_comb begin
    state_d      = state_q;
    rd_count_d   = rd_count_q;
    wr_count_d   = wr_count_q;
    out_addr_d   = out_addr_q;
    out_rd_d     = 1'b0;
    valid_d      = out_rd_q;
    write_nd_d   = pop;
    write_data_d = pop ? head : write_data_q;
    finished_d   = 1'b0;
    error_d      = error_q;

    starting     = (state_q == ST_IDLE) && start;
    rd_base      = starting ? '0 : rd_count_q;
    rd_next      = rd_base + CNT_ONE;
    wr_next      = wr_count_q + CNT_ONE;
    credit       = {1'b0, fifo_count} + {2'b00, out_rd_q} + {2'b00, valid_q};
    credit_limit = SKID_CREDITS + {2'b00, pop};

    if (start && (state_q != ST_IDLE)) begin
      error_d = 1'b1;
    end

    if (starting) begin
      state_d    = ST_ACTIVE;
      rd_count_d = '0;
      wr_count_d = '0;
      out_addr_d = '0;
    end

    if ((starting || (state_q == ST_ACTIVE)) && (rd_base < CNT_N) &&
        (credit < credit_limit)) begin
      out_rd_d   = 1'b1;
      out_addr_d = rd_base[LOG_N-1:0];
      rd_count_d = rd_next;
      if (rd_next == CNT_N) begin
        state_d = ST_DRAIN;
      end
    end

    if (pop && (state_q != ST_IDLE)) begin
      wr_count_d = wr_next;
      if (wr_next == CNT_N) begin
        finished_d = 1'b1;
        state_d    = ST_IDLE;
      end
    end
  end

  // State and output registers; reset abandons any transfer in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rd_count_q   <= '0;
      wr_count_q   <= '0;
      out_addr_q   <= '0;
      out_rd_q     <= 1'b0;
      valid_q      <= 1'b0;
      write_nd_q   <= 1'b0;
      write_data_q <= '0;
      finished_q   <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_count_q   <= rd_count_d;
      wr_count_q   <= wr_count_d;
      out_addr_q   <= out_addr_d;
      out_rd_q     <= out_rd_d;
      valid_q      <= valid_d;
      write_nd_q   <= write_nd_d;
      write_data_q <= write_data_d;
      finished_q   <= finished_d;
      error_q      <= error_d;
    end
  end

  assign out_addr   = out_addr_q;
  assign out_rd     = out_rd_q;
  assign write_nd   = write_nd_q;
  assign write_data = write_data_q;
  assign finished   = finished_q;
  assign error      = error_q;

endmodule
